// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// Grants bursts of up to MAX_BURST beats and never writes while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ-1:0]        req_mask_i,
    input  logic                    fifo_full_i,
    output logic                    fifo_wr_en_o,
    output logic [DATA_W-1:0]       fifo_wr_data_o,
    output logic                    grant_valid_o,
    output logic [ID_W-1:0]         grant_id_o,
    output logic [CNT_W-1:0]        beat_cnt_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [ID_W:0]    NReqW    = (ID_W + 1)'(N_REQ);
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(MAX_BURST - 1);

    state_e            state_q;
    logic              grant_valid_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   last_q;
    logic [CNT_W-1:0]  beat_cnt_q;

    logic [N_REQ-1:0]  ereq;
    logic              any_req;
    logic              in_grant;
    logic              grant_req;
    logic              xfer;
    logic              burst_end;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W:0]     idx;
    logic [DATA_W-1:0] grant_data;

    assign ereq      = req_valid_i & req_mask_i;
    assign any_req   = |ereq;
    assign in_grant  = (state_q == StGrant);
    assign grant_req = ereq[grant_id_q];
    assign xfer      = in_grant & grant_req & ~fifo_full_i;
    assign burst_end = (beat_cnt_q == LastBeat);

    // Scan offsets from largest to smallest so the nearest index after last_q wins.
    always_comb begin
        sel_id = '0;
        idx    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = {1'b0, last_q} + (ID_W + 1)'(off);
            if (idx >= NReqW) begin
                idx = idx - NReqW;
            end
            if (ereq[idx[ID_W-1:0]]) begin
                sel_id = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id_q == ID_W'(k)) begin
                grant_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (in_grant) begin
            req_ready_o[grant_id_q] = ~fifo_full_i;
        end
    end

    assign fifo_wr_en_o   = xfer;
    assign fifo_wr_data_o = in_grant ? grant_data : '0;
    assign grant_valid_o  = grant_valid_q;
    assign grant_id_o     = grant_id_q;
    assign beat_cnt_o     = beat_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            beat_cnt_q    <= '0;
            last_q        <= ID_W'(N_REQ - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q       <= StGrant;
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= sel_id;
                        beat_cnt_q    <= '0;
                        last_q        <= sel_id;
                    end
                end
                StGrant: begin
                    // Dropped/masked request or final beat ends the grant; full alone stalls.
                    if (!grant_req || (xfer && burst_end)) begin
                        state_q       <= StIdle;
                        grant_valid_q <= 1'b0;
                        beat_cnt_q    <= '0;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance, each checked every
// cycle against a queue-driven round-robin model, plus directed scenarios with literal results.
module tb_fifo_wr_arbiter;

    typedef struct {
        int id;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0]  valid_s [2];
    logic [3:0]  mask_s  [2];
    logic        full_s  [2];
    logic [31:0] data_s  [2];

    logic [3:0] rdy_a, rdy_b;
    logic       wr_a, wr_b;
    logic [7:0] wd_a, wd_b;
    logic       gv_a, gv_b;
    logic [1:0] gid_a, gid_b;
    logic [2:0] cnt_a;
    logic [0:0] cnt_b;

    bit [7:0] pend [2][4][$];
    wr_t      log_q [2][$];
    int       cyc = 0;
    int       errors = 0;
    int       checks = 0;

    // Model: grant holder, beats done in the grant, last granted index.
    int m_gv   [2] = '{0, 0};
    int m_gid  [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    int m_last [2] = '{3, 3};
    int mb     [2] = '{4, 1};

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid_s[0]), .req_data_i(data_s[0]), .req_ready_o(rdy_a),
        .req_mask_i(mask_s[0]), .fifo_full_i(full_s[0]),
        .fifo_wr_en_o(wr_a), .fifo_wr_data_o(wd_a),
        .grant_valid_o(gv_a), .grant_id_o(gid_a), .beat_cnt_o(cnt_a)
    );

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid_s[1]), .req_data_i(data_s[1]), .req_ready_o(rdy_b),
        .req_mask_i(mask_s[1]), .fifo_full_i(full_s[1]),
        .fifo_wr_en_o(wr_b), .fifo_wr_data_o(wd_b),
        .grant_valid_o(gv_b), .grant_id_o(gid_b), .beat_cnt_o(cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] er;
            bit found;
            er = valid_s[i] & mask_s[i];
            if (rst) begin
                m_gv[i] = 0; m_gid[i] = 0; m_cnt[i] = 0; m_last[i] = 3;
            end else if (m_gv[i] == 0) begin
                found = 0;
                for (int off = 1; off <= 4; off++) begin
                    int k;
                    k = (m_last[i] + off) % 4;
                    if (!found && er[k]) begin
                        found = 1; m_gv[i] = 1; m_gid[i] = k; m_cnt[i] = 0; m_last[i] = k;
                    end
                end
            end else if (!er[m_gid[i]]) begin
                m_gv[i] = 0; m_cnt[i] = 0;
            end else if (!full_s[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == mb[i]) begin
                    m_gv[i] = 0; m_cnt[i] = 0;
                end
            end
        end
    end

    // Requesters present the head of their queue and hold it until written.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [3:0]  v;
            logic [31:0] d;
            v = '0; d = '0;
            for (int k = 0; k < 4; k++) begin
                if (pend[i][k].size() != 0) begin
                    v[k] = 1'b1;
                    d[k*8 +: 8] = pend[i][k][0];
                end
            end
            valid_s[i] = v;
            data_s[i]  = d;
        end
    end

    task automatic cmp(input int i, input logic [3:0] rdy, input logic wr, input logic [7:0] wd,
                       input logic gv, input logic [1:0] gid, input int cnt);
        logic [3:0] er, e_rdy;
        logic       e_wr;
        logic [7:0] e_wd;
        er    = valid_s[i] & mask_s[i];
        e_rdy = (m_gv[i] != 0 && !full_s[i]) ? 4'(1 << m_gid[i]) : 4'b0;
        e_wr  = (m_gv[i] != 0) && er[m_gid[i]] && !full_s[i];
        e_wd  = (m_gv[i] != 0) ? data_s[i][m_gid[i]*8 +: 8] : 8'h00;
        checks++;
        if (rdy !== e_rdy || wr !== e_wr || wd !== e_wd || gv !== 1'(m_gv[i]) ||
            gid !== 2'(m_gid[i]) || cnt != m_cnt[i]) begin
            errors++;
            $display("FAIL cycle inst%0d cyc=%0d: got rdy=%b wr=%b wd=%h gv=%b gid=%0d cnt=%0d, expected rdy=%b wr=%b wd=%h gv=%0d gid=%0d cnt=%0d",
                     i, cyc, rdy, wr, wd, gv, gid, cnt, e_rdy, e_wr, e_wd, m_gv[i], m_gid[i],
                     m_cnt[i]);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        cmp(0, rdy_a, wr_a, wd_a, gv_a, gid_a, int'(cnt_a));
        cmp(1, rdy_b, wr_b, wd_b, gv_b, gid_b, int'(cnt_b));
        if (wr_a) begin
            e.id = int'(gid_a); e.data = int'(wd_a); e.cyc = cyc;
            log_q[0].push_back(e);
        end
        if (wr_b) begin
            e.id = int'(gid_b); e.data = int'(wd_b); e.cyc = cyc;
            log_q[1].push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            if (wr_a && rdy_a[k] && pend[0][k].size() != 0) void'(pend[0][k].pop_front());
            if (wr_b && rdy_b[k] && pend[1][k].size() != 0) void'(pend[1][k].pop_front());
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_log(input int i, input int n, input int budget);
        int t;
        t = 0;
        while (log_q[i].size() < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        if (log_q[i].size() < n) begin
            checks++; errors++;
            $display("FAIL timeout inst%0d: got %0d writes expected %0d", i, log_q[i].size(), n);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) pend[i][k].delete();
            log_q[i].delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        full_s = '{1'b0, 1'b0};
        mask_s = '{4'hF, 4'hF};
        @(negedge clk); #1;
        clear_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        valid_s = '{4'h0, 4'h0};
        data_s  = '{32'h0, 32'h0};
        mask_s  = '{4'hF, 4'hF};
        full_s  = '{1'b0, 1'b0};

        // Reset state and a single three-beat stream from requester 0.
        do_reset();
        @(negedge clk); #1;
        chk("reset_gv", int'(gv_a), 0);
        chk("reset_wr", int'(wr_a), 0);
        chk("reset_rdy", int'(rdy_a), 0);
        chk("reset_cnt", int'(cnt_a), 0);
        chk("reset_gid", int'(gid_a), 0);
        chk("reset_data", int'(wd_a), 0);
        pend[0][0] = '{8'h11, 8'h22, 8'h33};
        c0 = cyc;
        wait_log(0, 3, 20);
        for (int n = 0; n < 3; n++) begin
            chk("t1_id", log_q[0][n].id, 0);
            chk("t1_data", log_q[0][n].data, 17 * (n + 1));
            chk("t1_cyc", log_q[0][n].cyc - c0, n + 2);
        end
        repeat (2) begin @(negedge clk); #1; end
        chk("t1_idle", int'(gv_a), 0);
        chk("t1_count", log_q[0].size(), 3);

        // All four continuously valid: bursts of 4, one idle cycle between grants.
        do_reset();
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++) pend[0][k].push_back(8'(k * 16 + j));
        wait_log(0, 32, 200);
        for (int n = 0; n < 32; n++) begin
            int id;
            id = (n / 4) % 4;
            chk("t2_id", log_q[0][n].id, id);
            chk("t2_data", log_q[0][n].data, id * 16 + (n / 16) * 4 + n % 4);
            if (n > 0) chk("t2_gap", log_q[0][n].cyc - log_q[0][n-1].cyc, (n % 4 == 0) ? 2 : 1);
        end

        // Requester 2 stalled by full for 5 cycles after its second beat.
        do_reset();
        @(negedge clk); #1;
        pend[0][2] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        wait_log(0, 2, 20);
        @(posedge clk); #1;
        full_s[0] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); #1;
            chk("t3_rdy", int'(rdy_a), 0);
            chk("t3_wr", int'(wr_a), 0);
            chk("t3_cnt", int'(cnt_a), 2);
        end
        @(posedge clk); #1;
        full_s[0] = 1'b0;
        wait_log(0, 4, 20);
        chk("t3_d3", log_q[0][2].data, 'hA3);
        chk("t3_d4", log_q[0][3].data, 'hA4);
        chk("t3_stall", log_q[0][2].cyc - log_q[0][1].cyc, 6);
        @(negedge clk); #1;
        chk("t3_idle", int'(gv_a), 0);

        // Mask 1011: requester 2 skipped.
        do_reset();
        @(negedge clk); #1;
        mask_s[0] = 4'b1011;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++) pend[0][k].push_back(8'(k * 16 + j));
        wait_log(0, 13, 100);
        for (int n = 0; n < 13; n++) begin
            int ids [4];
            ids = '{0, 1, 3, 0};
            chk("t4_id", log_q[0][n].id, ids[n / 4]);
        end

        // Clearing mask bit 1 mid-grant ends the grant with no write.
        do_reset();
        @(negedge clk); #1;
        mask_s[0] = 4'b1011;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++) pend[0][k].push_back(8'(k * 16 + j));
        wait_log(0, 5, 50);
        chk("t4b_gid", log_q[0][4].id, 1);
        @(posedge clk); #1;
        mask_s[0] = 4'b1001;
        @(negedge clk); #1;
        chk("t4b_nowr", int'(wr_a), 0);
        chk("t4b_cnt", int'(cnt_a), 1);
        chk("t4b_logsz", log_q[0].size(), 5);
        @(negedge clk); #1;
        chk("t4b_idle", int'(gv_a), 0);
        wait_log(0, 6, 20);
        chk("t4b_next", log_q[0][5].id, 3);

        // Async reset during requester 3's third beat.
        do_reset();
        @(negedge clk); #1;
        pend[0][3] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        wait_log(0, 2, 20);
        @(posedge clk); #1;
        chk("t5_cnt", int'(cnt_a), 2);
        chk("t5_wr", int'(wr_a), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_wr", int'(wr_a), 0);
        chk("t5_rst_rdy", int'(rdy_a), 0);
        chk("t5_rst_data", int'(wd_a), 0);
        chk("t5_rst_gv", int'(gv_a), 0);
        chk("t5_rst_gid", int'(gid_a), 0);
        chk("t5_rst_cnt", int'(cnt_a), 0);
        @(negedge clk); #1;
        chk("t5_logsz", log_q[0].size(), 2);
        clear_all();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) pend[0][k].push_back(8'(k * 16 + j));
        @(posedge clk); #1;
        rst = 1'b0;
        wait_log(0, 1, 20);
        chk("t5_first", log_q[0][0].id, 0);

        // MAX_BURST=1 with requesters 1 and 3 valid.
        do_reset();
        @(negedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            pend[1][1].push_back(8'(16 + j));
            pend[1][3].push_back(8'(48 + j));
        end
        wait_log(1, 8, 60);
        for (int n = 0; n < 8; n++) begin
            int id;
            id = (n % 2 == 0) ? 1 : 3;
            chk("t6_id", log_q[1][n].id, id);
            chk("t6_data", log_q[1][n].data, id * 16 + n / 2);
            if (n > 0) chk("t6_gap", log_q[1][n].cyc - log_q[1][n-1].cyc, 2);
        end

        // Random traffic on both instances, checked cycle by cycle against the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 4; k++)
                    if (pend[i][k].size() < 6 && $urandom_range(0, 3) == 0)
                        pend[i][k].push_back(8'($urandom));
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 15) == 0) mask_s[i] = 4'($urandom);
                full_s[i] = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
